// File: rtl/scale_demux_reg_pkg.sv
// Shared definitions for scale_demux_reg: route codes, holding-slot state
// encoding, the default data width and the delivery counter width.
// Optional feature macro: SCALE_DEMUX_CNT_EN (per-channel delivery counters).
package scale_demux_reg_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    ROUTE_A    = 2'b00,
    ROUTE_B    = 2'b01,
    ROUTE_BOTH = 2'b10,
    ROUTE_RSVD = 2'b11
  } route_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready output handshake.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   i_load     - capture i_data at the next edge (caller guarantees slot free)
//   i_data     - word to capture
//   i_ready    - downstream consumer accepts
//   o_valid    - slot holds a word
//   o_data     - held word (stable while o_valid & !i_ready)
//   o_free_c   - combinational: slot can take a word this cycle
//   o_cnt      - delivered-word count (only with SCALE_DEMUX_CNT_EN)
module demux_slot
  import scale_demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_free_c
`ifdef SCALE_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next state: a load always wins over a drain in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (i_load) w_state_nxt = FULL;
      FULL:    if (!i_load && w_drain) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs decoded from state; free is combinational for 1 word/cycle pass-through
  always_comb begin
    o_valid  = 1'b0;
    w_drain  = 1'b0;
    o_free_c = 1'b1;
    o_valid  = (r_state == FULL);
    w_drain  = o_valid & i_ready;
    o_free_c = !o_valid | i_ready;
  end

  // Data holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  assign o_data = r_data;

`ifdef SCALE_DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Delivered-word counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/scale_demux_reg.sv
// Registered 1-to-2 demultiplexer: steers a producer word to channel A,
// channel B or both, each through its own one-entry holding slot.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_data/in_sel       - producer word and route (00 A, 01 B, 10 both, 11 reserved)
//   in_valid/in_ready    - producer handshake; in_ready never depends on in_valid
//   a_data/a_valid/a_ready - channel A output handshake
//   b_data/b_valid/b_ready - channel B output handshake
//   sel_err              - one-cycle pulse after a reserved-route word is accepted
//   a_cnt/b_cnt          - delivery counters (only with SCALE_DEMUX_CNT_EN)
module scale_demux_reg
  import scale_demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             sel_err
`ifdef SCALE_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);

  route_e w_route;
  logic   w_a_free_c;
  logic   w_b_free_c;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_load_a;
  logic   w_load_b;
  logic   r_sel_err;

  assign w_route = route_e'(in_sel);

  // Route decode; broadcast needs both slots free so it loads atomically
  always_comb begin
    w_in_ready = 1'b1;
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    case (w_route)
      ROUTE_A:    w_in_ready = w_a_free_c;
      ROUTE_B:    w_in_ready = w_b_free_c;
      ROUTE_BOTH: w_in_ready = w_a_free_c & w_b_free_c;
      default:    w_in_ready = 1'b1;
    endcase
    w_accept = in_valid & w_in_ready;
    w_load_a = w_accept & ((w_route == ROUTE_A) | (w_route == ROUTE_BOTH));
    w_load_b = w_accept & ((w_route == ROUTE_B) | (w_route == ROUTE_BOTH));
  end

  assign in_ready = w_in_ready;

  // Reserved route: word is swallowed, flagged for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sel_err <= 1'b0;
    else     r_sel_err <= w_accept & (w_route == ROUTE_RSVD);
  end

  assign sel_err = r_sel_err;

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load_a),
    .i_data   (in_data),
    .i_ready  (a_ready),
    .o_valid  (a_valid),
    .o_data   (a_data),
    .o_free_c (w_a_free_c)
`ifdef SCALE_DEMUX_CNT_EN
    ,
    .o_cnt    (a_cnt)
`endif
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load_b),
    .i_data   (in_data),
    .i_ready  (b_ready),
    .o_valid  (b_valid),
    .o_data   (b_data),
    .o_free_c (w_b_free_c)
`ifdef SCALE_DEMUX_CNT_EN
    ,
    .o_cnt    (b_cnt)
`endif
  );

endmodule

// File: tb/tb_scale_demux_reg.sv
// Self-checking bench for scale_demux_reg: directed vector table, hand-written
// reset / counter sequences, and randomized traffic against a reference model.
// Optional feature macro: SCALE_DEMUX_CNT_EN.
module tb_scale_demux_reg;
  import scale_demux_reg_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic         sel_err;
`ifdef SCALE_DEMUX_CNT_EN
  logic [7:0]   a_cnt;
  logic [7:0]   b_cnt;
`endif

  always #5 clk = ~clk;

  scale_demux_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .sel_err  (sel_err)
`ifdef SCALE_DEMUX_CNT_EN
    ,
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two one-word buffers plus counters, spec-level rules
  logic       ma_v, mb_v, m_err, m_rdy, s_rdy;
  logic [7:0] ma_d, mb_d;
  int         ma_cnt, mb_cnt;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       v;
    logic       ar;
    logic       br;
    logic       rdy;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [1:0] s, input logic ar, input logic br);
    logic fa, fb;
    fa = !ma_v || ar;
    fb = !mb_v || br;
    case (s)
      2'b00:   return fa;
      2'b01:   return fb;
      2'b10:   return fa && fb;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    ma_v = 1'b0; mb_v = 1'b0; m_err = 1'b0;
    ma_d = 8'h00; mb_d = 8'h00;
    ma_cnt = 0; mb_cnt = 0;
  endtask

  task automatic do_reset();
    in_data = '0; in_sel = 2'b00; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: drive at negedge, sample in_ready, step model at posedge, settle
  task automatic apply(input logic [1:0] s, input logic [7:0] d, input logic v,
                       input logic ar, input logic br);
    logic acc;
    @(negedge clk);
    in_sel = s; in_data = d; in_valid = v; a_ready = ar; b_ready = br;
    #1;
    s_rdy = in_ready;
    m_rdy = model_ready(s, ar, br);
    @(posedge clk);
    acc = v && m_rdy;
    if (ma_v && ar) ma_cnt = (ma_cnt + 1) % 256;
    if (mb_v && br) mb_cnt = (mb_cnt + 1) % 256;
    if (acc && (s == 2'b00 || s == 2'b10)) begin ma_v = 1'b1; ma_d = d; end
    else if (ar) ma_v = 1'b0;
    if (acc && (s == 2'b01 || s == 2'b10)) begin mb_v = 1'b1; mb_d = d; end
    else if (br) mb_v = 1'b0;
    m_err = acc && (s == 2'b11);
    #1;
  endtask

  task automatic check_model();
    chk("rand_in_ready", 32'(s_rdy), 32'(m_rdy));
    chk("rand_a_valid", 32'(a_valid), 32'(ma_v));
    chk("rand_b_valid", 32'(b_valid), 32'(mb_v));
    chk("rand_sel_err", 32'(sel_err), 32'(m_err));
    if (ma_v) chk("rand_a_data", 32'(a_data), 32'(ma_d));
    if (mb_v) chk("rand_b_data", 32'(b_data), 32'(mb_d));
`ifdef SCALE_DEMUX_CNT_EN
    chk("rand_a_cnt", 32'(a_cnt), 32'(ma_cnt));
    chk("rand_b_cnt", 32'(b_cnt), 32'(mb_cnt));
`endif
  endtask

  initial begin
    //            sel    data   v     ar    br  | rdy   av    ad     bv    bd     err
    vt[0]  = '{2'b00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{2'b00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{2'b00, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{2'b00, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
    vt[4]  = '{2'b01, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0};
    vt[5]  = '{2'b00, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 8'h5A, 1'b0};
    vt[6]  = '{2'b10, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0};
    vt[7]  = '{2'b10, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 8'h7E, 1'b0};
    vt[8]  = '{2'b11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 8'h7E, 1'b1};
    vt[9]  = '{2'b00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 8'h7E, 1'b0};
    vt[10] = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 8'h7E, 1'b1};
    vt[11] = '{2'b01, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[12] = '{2'b10, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h33, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_b_data", 32'(b_data), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);

    // Directed vector table
    foreach (vt[i]) begin
      apply(vt[i].sel, vt[i].data, vt[i].v, vt[i].ar, vt[i].br);
      chk($sformatf("vec%0d_in_ready", i), 32'(s_rdy), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_a_valid", i), 32'(a_valid), 32'(vt[i].av));
      chk($sformatf("vec%0d_b_valid", i), 32'(b_valid), 32'(vt[i].bv));
      chk($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'(vt[i].err));
      if (vt[i].av) chk($sformatf("vec%0d_a_data", i), 32'(a_data), 32'(vt[i].ad));
      if (vt[i].bv) chk($sformatf("vec%0d_b_data", i), 32'(b_data), 32'(vt[i].bd));
    end

    // Reset mid-transfer: valid must fall between edges
    do_reset();
    apply(2'b00, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("midrst_a_loaded", 32'(a_valid), 32'd1);
    chk("midrst_a_data_pre", 32'(a_data), 32'hAA);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_a_valid", 32'(a_valid), 32'd0);
    chk("midrst_a_data", 32'(a_data), 32'd0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0; in_sel = 2'b00;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

`ifdef SCALE_DEMUX_CNT_EN
    // 257 deliveries on A wrap the counter to 1
    do_reset();
    for (int k = 0; k < 257; k++) apply(2'b00, 8'($urandom), 1'b1, 1'b1, 1'b0);
    apply(2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("cnt_a_wrap", 32'(a_cnt), 32'd1);
    chk("cnt_b_zero", 32'(b_cnt), 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      apply(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
